// File: rtl/board_status_csr_if.sv
// Avalon-MM bus carrying host register reads and writes from the PCIe BAR
// to board_status_csr.
interface board_status_csr_if;
  logic [2:0]  avs_address;
  logic        avs_read;
  logic        avs_write;
  logic [31:0] avs_writedata;
  logic [3:0]  avs_byteenable;
  logic [31:0] avs_readdata;
  logic        avs_waitrequest;
  logic        avs_readdatavalid;

  modport master (
    output avs_address, avs_read, avs_write, avs_writedata, avs_byteenable,
    input  avs_readdata, avs_waitrequest, avs_readdatavalid
  );

  modport slave (
    input  avs_address, avs_read, avs_write, avs_writedata, avs_byteenable,
    output avs_readdata, avs_waitrequest, avs_readdatavalid
  );
endinterface

// File: rtl/board_status_csr.sv
// Board identity / calibration / PCIe reset-history CSR block with a 64-bit
// uptime counter and host-programmable LED driver, on the config clock.
module board_status_csr #(
  parameter logic [31:0] BOARD_ID  = 32'h5E5D_0001,
  parameter int unsigned BLINK_DIV = 25_000_000
) (
  input  logic                     clk,
  input  logic                     reset,
  board_status_csr_if.slave        avs,
  input  logic [3:0]               cal_success,
  input  logic [3:0]               cal_fail,
  input  logic                     pcie_npor,
  output logic [7:0]               leds
);

  typedef enum logic [2:0] {
    ADDR_ID, ADDR_SCRATCH, ADDR_STATUS, ADDR_STICKY,
    ADDR_LED_CTRL, ADDR_NPOR_COUNT, ADDR_UPTIME_LO, ADDR_UPTIME_HI
  } csr_addr_e;

  typedef enum logic [1:0] {LED_OFF, LED_STATIC, LED_BLINK, LED_HEARTBEAT} led_mode_e;

  localparam int unsigned         DIV_W    = $clog2(BLINK_DIV);
  localparam logic [DIV_W-1:0]    DIV_LAST = DIV_W'(BLINK_DIV - 1);

  logic [8:0]       sync1, sync2;
  logic [4:0]       edge_prev;
  logic [63:0]      cnt;
  logic [31:0]      shadow, scratch;
  logic [4:0]       sticky;
  logic [15:0]      npor_count;
  led_mode_e        led_mode;
  logic [7:0]       pattern;
  logic [DIV_W-1:0] div;
  logic             phase;
  logic             waitreq, rd_p1, rdv;
  logic [31:0]      rd_hold, rdata, rd_mux;
  logic [7:0]       led_next;

  wire [3:0]  cal_success_s = sync2[3:0];
  wire [3:0]  cal_fail_s    = sync2[7:4];
  wire        npor_s        = sync2[8];
  wire [3:0]  fail_rise     = cal_fail_s & ~edge_prev[3:0];
  wire        npor_fall     = ~npor_s & edge_prev[4];

  csr_addr_e  addr;
  assign addr = csr_addr_e'(avs.avs_address);

  // A read colliding with a write is dropped; the write still lands.
  wire        wr_acc = avs.avs_write & ~waitreq;
  wire        rd_acc = avs.avs_read & ~avs.avs_write & ~waitreq;
  wire [3:0]  be     = avs.avs_byteenable;
  wire [31:0] wmask  = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
  wire [4:0]  sticky_clr = (wr_acc && addr == ADDR_STICKY) ?
                           (avs.avs_writedata[4:0] & {5{be[0]}}) : 5'd0;
  wire        led_ctl_wr0 = wr_acc && addr == ADDR_LED_CTRL && be[0];

  assign avs.avs_waitrequest   = waitreq;
  assign avs.avs_readdatavalid = rdv;
  assign avs.avs_readdata      = rdata;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    rd_mux = '0;
    case (addr)
      ADDR_ID:         rd_mux = BOARD_ID;
      ADDR_SCRATCH:    rd_mux = scratch;
      ADDR_STATUS:     rd_mux = {23'd0, npor_s, cal_fail_s, cal_success_s};
      ADDR_STICKY:     rd_mux = {27'd0, sticky};
      ADDR_LED_CTRL:   rd_mux = {16'd0, pattern, 6'd0, led_mode};
      ADDR_NPOR_COUNT: rd_mux = {16'd0, npor_count};
      ADDR_UPTIME_LO:  rd_mux = cnt[31:0];
      ADDR_UPTIME_HI:  rd_mux = shadow;
      default:         rd_mux = '0;
    endcase
  end

  always_comb begin
    led_next = '0;
    case (led_mode)
      LED_OFF:       led_next = '0;
      LED_STATIC:    led_next = pattern;
      LED_BLINK:     led_next = phase ? pattern : 8'd0;
      LED_HEARTBEAT: led_next = {phase, 3'b000, cal_success_s};
      default:       led_next = '0;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1     <= '0;
      sync2     <= '0;
      edge_prev <= '0;
      cnt       <= '0;
    end else begin
      sync1     <= {pcie_npor, cal_fail, cal_success};
      sync2     <= sync1;
      edge_prev <= sync2[8:4];
      cnt       <= cnt + 64'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      scratch    <= '0;
      sticky     <= '0;
      npor_count <= '0;
      led_mode   <= LED_OFF;
      pattern    <= '0;
      shadow     <= '0;
    end else begin
      if (wr_acc && addr == ADDR_SCRATCH)
        scratch <= (scratch & ~wmask) | (avs.avs_writedata & wmask);
      // Set after clear: a new event beats a same-cycle W1C.
      sticky <= (sticky & ~sticky_clr) | {npor_fall, fail_rise};
      if (wr_acc && addr == ADDR_NPOR_COUNT)
        npor_count <= '0;
      else if (npor_fall && npor_count != 16'hFFFF)
        npor_count <= npor_count + 16'd1;
      if (led_ctl_wr0)
        led_mode <= led_mode_e'(avs.avs_writedata[1:0]);
      if (wr_acc && addr == ADDR_LED_CTRL && be[1])
        pattern <= avs.avs_writedata[15:8];
      if (rd_acc && addr == ADDR_UPTIME_LO)
        shadow <= cnt[63:32];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div   <= '0;
      phase <= 1'b0;
      leds  <= '0;
    end else begin
      if (led_ctl_wr0) begin
        div   <= '0;
        phase <= 1'b0;
      end else if (div == DIV_LAST) begin
        div   <= '0;
        phase <= ~phase;
      end else begin
        div <= div + DIV_W'(1);
      end
      leds <= led_next;
    end
  end

  // Two-stage read pipe: capture at accept, present one edge later.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      waitreq <= 1'b1;
      rd_p1   <= 1'b0;
      rd_hold <= '0;
      rdv     <= 1'b0;
      rdata   <= '0;
    end else begin
      waitreq <= 1'b0;
      rd_p1   <= rd_acc;
      if (rd_acc) rd_hold <= rd_mux;
      rdv     <= rd_p1;
      if (rd_p1) rdata <= rd_hold;
    end
  end

endmodule

// File: tb/tb_board_status_csr.sv
// Scoreboard bench for board_status_csr: reads push expected data and due
// cycle; a negedge monitor pops and compares on every readdatavalid.
module tb_board_status_csr;
  localparam logic [2:0] A_ID = 3'd0, A_SCRATCH = 3'd1, A_STATUS = 3'd2, A_STICKY = 3'd3,
                         A_LED = 3'd4, A_NPOR = 3'd5, A_LO = 3'd6, A_HI = 3'd7;

  typedef struct {
    logic [31:0] data;
    int          due;
    string       name;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  cal_success = 4'd0;
  logic [3:0]  cal_fail = 4'd0;
  logic        pcie_npor = 1'b1;
  logic [7:0]  leds;
  int          cyc = 0;
  logic [63:0] tb_cnt;
  int          n_checks = 0;
  int          n_fail = 0;
  exp_t        sb[$];
  exp_t        mon_e;

  board_status_csr_if bus();

  board_status_csr #(.BOARD_ID(32'h5E5D_0001), .BLINK_DIV(4)) dut (
    .clk(clk), .reset(reset), .avs(bus.slave),
    .cal_success(cal_success), .cal_fail(cal_fail), .pcie_npor(pcie_npor), .leds(leds)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference uptime: free-running from reset release.
  always @(posedge clk or posedge reset)
    if (reset) tb_cnt <= '0;
    else       tb_cnt <= tb_cnt + 64'd1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (bus.avs_readdatavalid === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_readdatavalid", {63'd0, bus.avs_readdatavalid}, 64'd0);
      end else begin
        mon_e = sb.pop_front();
        check(mon_e.name, {32'd0, bus.avs_readdata}, {32'd0, mon_e.data});
        check({mon_e.name, "_latency"}, 64'(cyc), 64'(mon_e.due));
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_ready();
    int w = 0;
    while (bus.avs_waitrequest !== 1'b0 && w < 20) begin
      step(1);
      w++;
    end
    if (w == 20) check("waitrequest_timeout", {63'd0, bus.avs_waitrequest}, 64'd0);
  endtask

  task automatic bus_read(input logic [2:0] a, input logic [31:0] exp, input string name);
    exp_t e;
    wait_ready();
    e.data = exp;
    e.due  = cyc + 2;
    e.name = name;
    sb.push_back(e);
    bus.avs_address = a;
    bus.avs_read    = 1'b1;
    step(1);
    bus.avs_read    = 1'b0;
  endtask

  task automatic bus_write(input logic [2:0] a, input logic [31:0] d, input logic [3:0] b);
    wait_ready();
    bus.avs_address    = a;
    bus.avs_writedata  = d;
    bus.avs_byteenable = b;
    bus.avs_write      = 1'b1;
    step(1);
    bus.avs_write      = 1'b0;
  endtask

  initial begin
    bus.avs_address = '0; bus.avs_read = 1'b0; bus.avs_write = 1'b0;
    bus.avs_writedata = '0; bus.avs_byteenable = '0;

    // Reset state
    step(2);
    check("rst_waitrequest", {63'd0, bus.avs_waitrequest}, 64'd1);
    check("rst_readdatavalid", {63'd0, bus.avs_readdatavalid}, 64'd0);
    check("rst_readdata", {32'd0, bus.avs_readdata}, 64'd0);
    check("rst_leds", {56'd0, leds}, 64'd0);
    reset = 1'b0;
    check("waitrequest_before_edge", {63'd0, bus.avs_waitrequest}, 64'd1);
    step(1);
    check("waitrequest_after_edge", {63'd0, bus.avs_waitrequest}, 64'd0);

    // Back-to-back reads
    bus_read(A_ID, 32'h5E5D_0001, "rd_id");
    bus_read(A_SCRATCH, 32'h0, "rd_scratch_rst");
    bus_read(A_HI, 32'h0, "rd_hi_rst");
    step(3);

    // SCRATCH byte enables and RO write ignored
    bus_write(A_SCRATCH, 32'hDEAD_BEEF, 4'b0101);
    bus_read(A_SCRATCH, 32'h00AD_00EF, "rd_scratch_be");
    bus_write(A_ID, 32'hFFFF_FFFF, 4'hF);
    bus_read(A_ID, 32'h5E5D_0001, "rd_id_ro");

    // Simultaneous read+write: write lands, no response
    bus.avs_address = A_SCRATCH; bus.avs_writedata = 32'h1234_5678; bus.avs_byteenable = 4'hF;
    bus.avs_read = 1'b1; bus.avs_write = 1'b1;
    step(1);
    bus.avs_read = 1'b0; bus.avs_write = 1'b0;
    bus_read(A_SCRATCH, 32'h1234_5678, "rd_scratch_rw_collide");
    step(3);

    // PCIe reset history
    for (int i = 0; i < 3; i++) begin
      pcie_npor = 1'b0; step(3);
      pcie_npor = 1'b1; step(3);
    end
    step(3);
    bus_read(A_NPOR, 32'd3, "rd_npor_count");
    bus_read(A_STICKY, 32'h10, "rd_sticky_npor");
    bus_write(A_STICKY, 32'h10, 4'hF);
    bus_read(A_STICKY, 32'h0, "rd_sticky_w1c");
    bus_write(A_NPOR, 32'h0, 4'h1);
    bus_read(A_NPOR, 32'h0, "rd_npor_cleared");
    step(3);

    // Calibration status and sticky set-wins-over-W1C
    cal_success = 4'b1010; cal_fail = 4'b0100;
    step(4);
    bus_read(A_STATUS, 32'h0000_014A, "rd_status");
    bus_read(A_STICKY, 32'h4, "rd_sticky_fail");
    cal_fail = 4'b0000;
    step(4);
    cal_fail = 4'b0100;
    step(2);
    bus_write(A_STICKY, 32'h4, 4'hF);
    bus_read(A_STICKY, 32'h4, "rd_sticky_set_wins");
    bus_write(A_STICKY, 32'h4, 4'hF);
    bus_read(A_STICKY, 32'h0, "rd_sticky_clear_no_edge");
    step(3);

    // LED modes
    bus_write(A_LED, 32'h0000_3C01, 4'b0011);
    check("leds_registered", {56'd0, leds}, 64'h0);
    step(1);
    check("leds_static", {56'd0, leds}, 64'h3C);
    bus_write(A_LED, 32'h0000_0003, 4'b0001);
    step(1);
    check("leds_heartbeat", {56'd0, leds}, 64'h0A);
    bus_read(A_LED, 32'h0000_3C03, "rd_led_ctrl");
    bus_write(A_LED, 32'h0000_A502, 4'b0011);
    for (int i = 1; i <= 12; i++) begin
      step(1);
      check($sformatf("leds_blink_%0d", i), {56'd0, leds}, (((i - 1) / 4) % 2 == 1) ? 64'hA5 : 64'h0);
    end

    // Uptime
    step(100);
    bus_read(A_LO, tb_cnt[31:0], "rd_uptime_lo");
    bus_read(A_HI, 32'h0, "rd_uptime_hi");
    step(3);
    force dut.cnt = 64'h0000_0000_FFFF_FFFE;
    #1;
    release dut.cnt;
    step(4);
    bus_read(A_LO, 32'h0000_0002, "rd_uptime_lo_wrap");
    bus_read(A_HI, 32'h0000_0001, "rd_uptime_hi_wrap");
    step(3);

    // Reset during an outstanding read: response must be discarded
    bus.avs_address = A_ID; bus.avs_read = 1'b1;
    step(1);
    bus.avs_read = 1'b0;
    reset = 1'b1;
    step(2);
    check("midrst_waitrequest", {63'd0, bus.avs_waitrequest}, 64'd1);
    check("midrst_leds", {56'd0, leds}, 64'd0);
    reset = 1'b0;
    step(5);
    bus_read(A_SCRATCH, 32'h0, "rd_scratch_after_reset");

    for (int i = 0; i < 20 && sb.size() != 0; i++) step(1);
    check("scoreboard_drained", 64'(sb.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/board_status_csr.md
# board_status_csr

Avalon-MM register responder that answers host reads and writes arriving through the PCIe BAR. It exposes board identity, memory-calibration status, PCIe reset history and a 64-bit uptime counter. It also drives the eight board LEDs from a host-programmable mode and pattern, replacing the constant LED tie-off in the board top level. It sits in the board top level, beside the system instance, on the config clock domain.

## Interface
- `BOARD_ID`, default 32'h5E5D_0001, value returned at word 0.
- `BLINK_DIV`, default 25_000_000, clk cycles per LED phase toggle; must be ≥ 2.
- `clk` input 1: single clock (50 MHz config clock). One clock only.
- `reset` input 1: asynchronous, active-high reset.
- `avs_address` input 3: word address.
- `avs_read` input 1: read request.
- `avs_write` input 1: write request.
- `avs_writedata` input 32: write data.
- `avs_byteenable` input 4: byte lanes for writes.
- `avs_readdata` output 32: read data, valid with `avs_readdatavalid`.
- `avs_waitrequest` output 1: stall.
- `avs_readdatavalid` output 1: read response strobe.
- `cal_success` input 4: per-memory calibration pass (asynchronous).
- `cal_fail` input 4: per-memory calibration fail (asynchronous).
- `pcie_npor` input 1: PCIe reset status, active-low (asynchronous).
- `leds` output 8: board LEDs.

## Operation
- Inputs `cal_success`, `cal_fail` and `pcie_npor` each pass through a 2-flop synchronizer. Synchronizer flops reset to 0. Edge detection runs on the synchronized values.
- Register map (word address):
  - 0 ID: RO, `BOARD_ID`.
  - 1 SCRATCH: RW, 32 bits, byteenable honoured.
  - 2 STATUS: RO. [3:0] cal_success_s, [7:4] cal_fail_s, [8] npor_s, others 0.
  - 3 STICKY: W1C, byteenable honoured.
    - [3:0] set on a rising edge of cal_fail_s.
    - [4] set on a falling edge of npor_s.
    - A set event and a W1C on the same bit in the same cycle: the set wins.
  - 4 LED_CTRL: RW. [1:0] mode, [15:8] pattern, byteenable honoured. Any write to byte 0 clears the blink divider and the phase.
  - 5 NPOR_COUNT: [15:0] count of npor_s falling edges, saturating at 16'hFFFF. Any write clears it to 0. A write and an edge in the same cycle give 0.
  - 6 UPTIME_LO: RO. Returns cnt[31:0] sampled in the accept cycle, and loads the shadow with cnt[63:32] in that same cycle.
  - 7 UPTIME_HI: RO, returns the shadow.
- Writes to RO registers are ignored.
- The uptime counter `cnt` is 64 bits, free-running and increments every cycle. It wraps from all-ones to 0.
- Blink divider counts 0..BLINK_DIV-1. On reaching BLINK_DIV-1 it wraps to 0 and toggles `phase`.
- LED modes:
  - 0 OFF: leds=0.
  - 1 STATIC: leds=pattern.
  - 2 BLINK: leds=pattern when phase=1, else 0.
  - 3 HEARTBEAT: leds={phase, 3'b0, cal_success_s}.
- Simultaneous `avs_read` and `avs_write` is a protocol error. The write is performed, the read is dropped and no readdatavalid is issued.

## Timing
- Reset values:
  - avs_waitrequest=1.
  - avs_readdatavalid=0 and avs_readdata=0.
  - leds=0.
  - All registers, counters, shadow, divider, phase and synchronizers are 0.
- avs_waitrequest is 1 while `reset` is high and 0 from the first clk edge after release. It is never asserted otherwise.
- Accept means read or write high while avs_waitrequest=0.
- Read latency is fixed at 2: avs_readdatavalid pulses one cycle exactly 2 cycles after acceptance.
- avs_readdata holds its value until the next response.
- Back-to-back reads are accepted every cycle. Responses come back in order, at most 2 outstanding.
- A write takes effect in the accept cycle. A read accepted in the next cycle sees the new value.
- Input-to-sticky latency: an input change is reflected in STICKY and NPOR_COUNT 3 clk edges later (2 synchronizer stages plus the edge register).
- LED outputs are registered: 1 cycle after a LED_CTRL write or a phase change.
- Reset asserted mid-read: the pending response is discarded and no readdatavalid is issued after release.

## Test plan
- Reset, then read words 0, 1 and 7 back-to-back → readdatavalid on cycles +2, +3 and +4 with 32'h5E5D_0001, 0 and 0.
- Write SCRATCH 32'hDEAD_BEEF with be=4'b0101, then read → 32'h00AD_00EF.
- Pulse pcie_npor low 3 times → NPOR_COUNT=3 and STICKY[4]=1. Then write STICKY 32'h10 → STICKY reads 0. Write NPOR_COUNT → reads 0.
- Drive cal_fail[2] high in the same cycle that STICKY[2] is W1C'd with the edge arriving → STICKY[2] remains 1.
- BLINK_DIV=4, LED_CTRL=mode 2 with pattern 8'hA5 → leds alternates 8'h00 / 8'hA5 every 4 cycles, starting at 8'h00.
- Run 100 cycles, then read UPTIME_LO then UPTIME_HI → the LO value equals the accept-cycle count. HI=0 with no wrap. With cnt preloaded by force to 64'h0000_0000_FFFF_FFFE, HI=1 once cnt has crossed the boundary and LO has been re-read.
